adc_frame_packer: RTL and testbench
===================================

ADC_FRAME_PACKER -- requirements
Module: adc_frame_packer

Interface
REQ-001 Parameter N_CH, 10: number of ADC channels per input frame.
REQ-002 Parameter SAMPLE_W, 16: bits per channel sample.
REQ-003 Parameter OUT_W, 256: output word width; OUT_W SHALL be a multiple of SAMPLE_W and OUT_W >= N_CH*SAMPLE_W.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 i_start  in  1  one-cycle start pulse.
REQ-007 i_samples_count  in  32  number of frames to accept per run; sampled on i_start.
REQ-008 i_ch_mask  in  N_CH  channel enable mask, bit n = channel n; sampled on i_start.
REQ-009 i_data  in  N_CH*SAMPLE_W  frame, channel n at bits [n*SAMPLE_W +: SAMPLE_W].
REQ-010 i_valid  in  1  frame present on i_data.
REQ-011 i_ready  in  1  downstream FIFO has room for one more output word.
REQ-012 o_data  out  OUT_W  packed output word, slot 0 at LSBs.
REQ-013 o_wr_en  out  1  o_data valid; one-cycle write strobe.
REQ-014 o_busy  out  1  high while a run is in progress.
REQ-015 o_finished  out  1  one-cycle pulse at end of run.
REQ-016 o_overflow  out  1  sticky: a frame was dropped in the current run.
REQ-017 o_frame_cnt  out  32  frames accepted in the current run.

Function
REQ-018 States IDLE, RUN, FLUSH, DONE; IDLE->RUN on i_start with latched count > 0; IDLE->DONE on i_start with count = 0.
REQ-019 i_start outside IDLE SHALL be ignored; mask and count SHALL NOT change mid-run.
REQ-020 In RUN, a frame is accepted when i_valid & i_ready; K = popcount(latched mask) samples taken, ascending channel index.
REQ-021 Accepted samples fill consecutive SAMPLE_W slots of an accumulator; a frame straddling a word boundary SHALL finish the current word and carry its remainder into slot 0 of the next.
REQ-022 o_wr_en SHALL assert exactly one cycle after the accepting cycle that fills the last slot; at most one word per cycle.
REQ-023 i_valid & ~i_ready in RUN: frame dropped, not counted, o_overflow set until next i_start.
REQ-024 o_frame_cnt increments on every accepted frame; RUN->FLUSH when it reaches the latched count.
REQ-025 FLUSH: if slots partially filled, emit one word with unfilled slots zero once i_ready is high, then DONE; if empty, go straight to DONE.
REQ-026 DONE lasts one cycle with o_finished = 1, then IDLE; o_frame_cnt holds until the next i_start.
REQ-027 Mask all zero: frames counted, no words emitted, no flush word.
REQ-028 o_busy = 1 in RUN and FLUSH only.

Reset
REQ-029 On rst: state IDLE, accumulator and slot pointer cleared, o_data = 0, o_wr_en = 0, o_busy = 0, o_finished = 0, o_overflow = 0, o_frame_cnt = 0.
REQ-030 rst mid-run SHALL abort immediately with no flush word and no o_finished pulse.

Structure
REQ-031 Package adc_acq_pkg SHALL hold the state encoding and default N_CH/SAMPLE_W/OUT_W constants.
REQ-032 Sub-module adc_ch_compact SHALL perform the combinational mask compaction and popcount; all state stays in adc_frame_packer.

Verification
REQ-033 Mask 0x3FF, count 8, i_ready = 1, continuous valid -> 80 samples = 5 words, no flush, o_finished one cycle after 5th word.
REQ-034 Mask 0x3FF, count 3, i_ready = 1 -> 2 words; second word holds 14 samples in slots 0-13, slots 14-15 zero.
REQ-035 Mask 0x005, count 9, frame n = {ch0 = n, ch2 = 0x100+n} -> word 0 slots = 0,0x100,1,0x101,... through 7,0x107; flush word slots 0-1 = 8,0x108, rest zero.
REQ-036 Mask 0x3FF, count 4, i_ready low during frame 2 -> frame 2 dropped, o_overflow = 1, o_frame_cnt reaches 4 one frame later.
REQ-037 Count 0 -> o_finished pulse, zero o_wr_en; i_start during RUN -> ignored; rst after 2 frames -> all outputs 0, no o_finished.

Source files
------------

// File: rtl/adc_acq_pkg.sv
// Shared definitions for the ADC acquisition blocks: the packer state
// encoding and the default frame/word geometry.
package adc_acq_pkg;

    localparam int DEF_N_CH     = 10;
    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_OUT_W    = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of sample slots carried by one output word.
    function automatic int slots_per_word(input int out_w, input int sample_w);
        return out_w / sample_w;
    endfunction

endpackage

// File: rtl/adc_ch_compact.sv
// Combinational channel compaction: gathers the enabled channels of a frame
// into consecutive low slots (ascending channel index) and counts them.
module adc_ch_compact
    import adc_acq_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int CNT_W    = $clog2(N_CH + 1)
) (
    input  logic [N_CH-1:0]          mask,
    input  logic [N_CH*SAMPLE_W-1:0] data,
    output logic [N_CH*SAMPLE_W-1:0] compact_data,
    output logic [CNT_W-1:0]         count
);

    int k;

    // Walk the channels in order, dropping each enabled sample into the next free slot.
    always_comb begin
        compact_data = '0;
        k            = 0;
        for (int n = 0; n < N_CH; n++) begin
            if (mask[n]) begin
                compact_data[k*SAMPLE_W +: SAMPLE_W] = data[n*SAMPLE_W +: SAMPLE_W];
                k = k + 1;
            end
        end
        count = CNT_W'(k);
    end

endmodule

// File: rtl/adc_frame_packer.sv
// Packs the enabled channels of accepted ADC frames into wide output words,
// carrying frames that straddle a word boundary into the next word and
// flushing a zero-padded partial word at the end of a run.
module adc_frame_packer
    import adc_acq_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int OUT_W    = DEF_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [31:0]              i_samples_count,
    input  logic [N_CH-1:0]          i_ch_mask,
    input  logic [N_CH*SAMPLE_W-1:0] i_data,
    input  logic                     i_valid,
    input  logic                     i_ready,
    output logic [OUT_W-1:0]         o_data,
    output logic                     o_wr_en,
    output logic                     o_busy,
    output logic                     o_finished,
    output logic                     o_overflow,
    output logic [31:0]              o_frame_cnt
);

    localparam int SLOTS  = slots_per_word(OUT_W, SAMPLE_W);
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int SUM_W  = SLOT_W + 1;
    localparam int CNT_W  = $clog2(N_CH + 1);
    localparam int IN_W   = N_CH * SAMPLE_W;
    localparam logic [SUM_W-1:0] SLOTS_S = SUM_W'(SLOTS);

    state_t              state;
    state_t              state_next;
    logic [31:0]         cnt_lat;
    logic [N_CH-1:0]     mask_lat;
    logic [OUT_W-1:0]    acc;
    logic [SLOT_W-1:0]   ptr;
    logic [IN_W-1:0]     compact_data;
    logic [CNT_W-1:0]    k_count;
    logic [SUM_W-1:0]    sum;
    logic [2*OUT_W-1:0]  combined;
    logic                accept;
    logic                wrap;
    logic                last_frame;

    adc_ch_compact #(
        .N_CH     (N_CH),
        .SAMPLE_W (SAMPLE_W),
        .CNT_W    (CNT_W)
    ) u_compact (
        .mask         (mask_lat),
        .data         (i_data),
        .compact_data (compact_data),
        .count        (k_count)
    );

    // The compacted frame is shifted up to the current slot; anything past the
    // top of the word lands in the upper half and becomes the next word's start.
    assign accept     = (state == ST_RUN) & i_valid & i_ready;
    assign sum        = SUM_W'(ptr) + SUM_W'(k_count);
    assign wrap       = (sum >= SLOTS_S);
    assign combined   = {{OUT_W{1'b0}}, acc}
                      | ({{(2*OUT_W-IN_W){1'b0}}, compact_data} << (int'(ptr) * SAMPLE_W));
    assign last_frame = ((o_frame_cnt + 32'd1) == cnt_lat);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state decode plus the status outputs that follow directly from the state.
    always_comb begin
        state_next = state;
        o_busy     = 1'b0;
        o_finished = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) state_next = (i_samples_count != 32'd0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (accept && last_frame) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                o_busy = 1'b1;
                if ((ptr == '0) || i_ready) state_next = ST_DONE;
            end
            ST_DONE: begin
                o_finished = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Run configuration, frame counting, overflow tracking and word assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_lat     <= '0;
            mask_lat    <= '0;
            acc         <= '0;
            ptr         <= '0;
            o_data      <= '0;
            o_wr_en     <= 1'b0;
            o_overflow  <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            o_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        cnt_lat     <= i_samples_count;
                        mask_lat    <= i_ch_mask;
                        acc         <= '0;
                        ptr         <= '0;
                        o_overflow  <= 1'b0;
                        o_frame_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        o_frame_cnt <= o_frame_cnt + 32'd1;
                        if (wrap) begin
                            o_data  <= combined[OUT_W-1:0];
                            o_wr_en <= 1'b1;
                            acc     <= combined[2*OUT_W-1:OUT_W];
                            ptr     <= SLOT_W'(sum - SLOTS_S);
                        end else begin
                            acc <= combined[OUT_W-1:0];
                            ptr <= SLOT_W'(sum);
                        end
                    end else if (i_valid) begin
                        o_overflow <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if ((ptr != '0) && i_ready) begin
                        o_data  <= acc;
                        o_wr_en <= 1'b1;
                        acc     <= '0;
                        ptr     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Randomized scoreboard bench for adc_frame_packer: a sample-stream model
// predicts output words, a monitor compares every write strobe against it.
module tb_adc_frame_packer;

    localparam int N_CH  = 10;
    localparam int SW    = 16;
    localparam int OW    = 256;
    localparam int SLOTS = OW / SW;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_start;
    logic [31:0]        i_samples_count;
    logic [N_CH-1:0]    i_ch_mask;
    logic [N_CH*SW-1:0] i_data;
    logic               i_valid;
    logic               i_ready;
    logic [OW-1:0]      o_data;
    logic               o_wr_en;
    logic               o_busy;
    logic               o_finished;
    logic               o_overflow;
    logic [31:0]        o_frame_cnt;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            fin_cnt = 0;
    time           last_wr_t = 0;
    time           fin_t = 0;
    logic [OW-1:0] exp_q[$];
    logic [SW-1:0] samp_q[$];

    adc_frame_packer #(.N_CH(N_CH), .SAMPLE_W(SW), .OUT_W(OW)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_samples_count (i_samples_count),
        .i_ch_mask       (i_ch_mask),
        .i_data          (i_data),
        .i_valid         (i_valid),
        .i_ready         (i_ready),
        .o_data          (o_data),
        .o_wr_en         (o_wr_en),
        .o_busy          (o_busy),
        .o_finished      (o_finished),
        .o_overflow      (o_overflow),
        .o_frame_cnt     (o_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Move up to one word of samples from the stream model into the expected queue, zero padded.
    task automatic pushWord();
        logic [OW-1:0] w;
        w = '0;
        for (int i = 0; i < SLOTS; i++)
            if (samp_q.size() > 0) w[i*SW +: SW] = samp_q.pop_front();
        exp_q.push_back(w);
    endtask

    // Monitor: every write strobe must match the oldest predicted word.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_finished) begin
                fin_cnt++;
                fin_t = $time;
            end
            if (o_wr_en) begin
                last_wr_t = $time;
                if (exp_q.size() == 0) checkOutput("unexpected_word", o_wr_en, 0);
                else                   checkOutput("word", o_data, exp_q.pop_front());
            end
        end
    end

    // One complete run. ready_mode: 0 always ready, 1 random, 2 not ready on presented frame 2.
    task automatic applyStimulus(input int cnt, input logic [N_CH-1:0] mask, input int ready_mode,
                                 input bit valid_rand, input bit pattern, input bit stray_start);
        int            accepted = 0;
        int            presented = 0;
        int            guard = 0;
        int            fin_before;
        bit            exp_ovf = 0;
        bit            done = 0;
        logic          v, r;
        logic [SW-1:0] s;
        logic [N_CH*SW-1:0] d;

        @(posedge clk); #1;
        i_start = 1'b1; i_samples_count = cnt; i_ch_mask = mask; i_valid = 1'b0; i_ready = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_samples_count = $urandom; i_ch_mask = N_CH'($urandom);
        fin_before = fin_cnt;
        if (cnt > 0) checkOutput("busy_in_run", o_busy, 1);

        while (accepted < cnt && guard < 2000) begin
            guard++;
            v = valid_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            case (ready_mode)
                1:       r = ($urandom_range(0, 3) != 0);
                2:       r = (presented != 2);
                default: r = 1'b1;
            endcase
            for (int c = 0; c < N_CH; c++) begin
                s = pattern ? SW'(c * 'h80 + accepted) : SW'($urandom_range(0, 65535));
                d[c*SW +: SW] = s;
            end
            i_valid = v; i_ready = r; i_data = d;
            i_start = (stray_start && accepted == 1);
            if (v) begin
                presented++;
                if (r) begin
                    accepted++;
                    for (int c = 0; c < N_CH; c++)
                        if (mask[c]) samp_q.push_back(d[c*SW +: SW]);
                    if (samp_q.size() >= SLOTS) pushWord();
                end else begin
                    exp_ovf = 1;
                end
            end
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_start = 1'b0;
        if (samp_q.size() > 0) pushWord();

        for (int g = 0; g < 200 && !done; g++) begin
            i_ready = (ready_mode == 1) ? ($urandom_range(0, 1) != 0) : 1'b1;
            @(negedge clk);
            if (o_finished) done = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!done) checkOutput("finish_timeout", o_finished, 1);
        checkOutput("frame_cnt", o_frame_cnt, cnt);
        checkOutput("overflow", o_overflow, exp_ovf);
        checkOutput("busy_at_done", o_busy, 0);
        @(posedge clk); @(negedge clk);
        checkOutput("finish_pulses", fin_cnt - fin_before, 1);
        checkOutput("finish_dropped", o_finished, 0);
        checkOutput("frame_cnt_hold", o_frame_cnt, cnt);
        checkOutput("words_outstanding", exp_q.size(), 0);
        exp_q.delete();
        samp_q.delete();
    endtask

    // Reset in the middle of a run: everything clears and no completion appears.
    task automatic resetMidRun();
        int fin_before;
        @(posedge clk); #1;
        i_start = 1'b1; i_samples_count = 10; i_ch_mask = 'h003; i_valid = 1'b0; i_ready = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_valid = 1'b1; i_ready = 1'b0; i_data = {N_CH{16'h1234}};
        @(posedge clk); #1;
        i_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        fin_before = fin_cnt;
        @(negedge clk);
        checkOutput("pre_reset_overflow", o_overflow, 1);
        checkOutput("pre_reset_frames", o_frame_cnt, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_data", o_data, 0);
        checkOutput("rst_wr_en", o_wr_en, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_finished", o_finished, 0);
        checkOutput("rst_overflow", o_overflow, 0);
        checkOutput("rst_frame_cnt", o_frame_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_no_finish", fin_cnt - fin_before, 0);
        checkOutput("rst_idle_busy", o_busy, 0);
        exp_q.delete();
        samp_q.delete();
    endtask

    // Test sequence: reset state, directed cases, then randomized runs.
    initial begin
        int cnt;
        logic [N_CH-1:0] mask;
        rst = 1'b1; i_start = 1'b0; i_samples_count = '0; i_ch_mask = '0;
        i_data = '0; i_valid = 1'b0; i_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_data", o_data, 0);
        checkOutput("reset_wr_en", o_wr_en, 0);
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_finished", o_finished, 0);
        checkOutput("reset_overflow", o_overflow, 0);
        checkOutput("reset_frame_cnt", o_frame_cnt, 0);
        rst = 1'b0;

        $display("[TB] full mask, 8 frames");
        applyStimulus(8, 'h3FF, 0, 0, 0, 0);
        checkOutput("finish_after_last_word", fin_t - last_wr_t, 10);
        $display("[TB] full mask, 3 frames");
        applyStimulus(3, 'h3FF, 0, 0, 0, 0);
        $display("[TB] mask 0x005, 9 patterned frames");
        applyStimulus(9, 'h005, 0, 0, 1, 0);
        $display("[TB] dropped frame 2");
        applyStimulus(4, 'h3FF, 2, 0, 0, 0);
        $display("[TB] zero count");
        applyStimulus(0, 'h3FF, 0, 0, 0, 0);
        $display("[TB] start during run");
        applyStimulus(5, 'h3FF, 0, 0, 0, 1);
        $display("[TB] zero mask");
        applyStimulus(6, 'h000, 1, 1, 0, 0);
        $display("[TB] reset mid run");
        resetMidRun();

        for (int t = 0; t < 12; t++) begin
            cnt  = $urandom_range(1, 20);
            mask = ($urandom_range(0, 5) == 0) ? '0 : N_CH'($urandom);
            $display("[TB] random run %0d: count %0d mask %0h", t, cnt, mask);
            applyStimulus(cnt, mask, 1, 1, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
